// File: rtl/sync_cell_fifo_pkg.sv
// Shared definitions for the synchronous cell FIFO: write-controller state
// encoding, FIFO word field positions and small protocol helpers.
package sync_cell_fifo_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;

  // FIFO word is {sop, eop, data}; marker positions depend on payload width
  function automatic int sop_bit(input int dwidth);
    return dwidth + 1;
  endfunction

  function automatic int eop_bit(input int dwidth);
    return dwidth;
  endfunction

  // A sop inside a packet, or a non-sop word outside one, breaks framing
  function automatic logic proto_violation(input logic sop, input logic in_pkt);
    return (sop & in_pkt) | (~sop & ~in_pkt);
  endfunction

  // Packet-open flag after an accepted word; eop wins over sop
  function automatic logic in_pkt_next(input logic sop, input logic eop,
                                       input logic in_pkt);
    logic nxt;
    if (eop) begin
      nxt = 1'b0;
    end else if (sop) begin
      nxt = 1'b1;
    end else begin
      nxt = in_pkt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sync_cell_fifo_wr.sv
// Write controller for the cell FIFO: cuts a sop/eop word stream into
// fixed 2^CWIDTH-word cells, padding a short final cell to full length.
module sync_cell_fifo_wr
  import sync_cell_fifo_pkg::*;
#(
  parameter int                DWIDTH   = 8,
  parameter int                CWIDTH   = 2,
  parameter logic [DWIDTH-1:0] PAD_DATA = {DWIDTH{1'b0}},
  parameter int                U_DLY    = 1
) (
  input  logic                i_clk_sys,
  input  logic                i_rst,
  input  logic                i_s_valid,
  input  logic                i_s_sop,
  input  logic                i_s_eop,
  input  logic [DWIDTH-1:0]   i_s_data,
  output logic                o_s_ready,
  output logic                o_f_wen,
  output logic                o_f_weoc,
  output logic [CWIDTH-1:0]   o_f_waddr,
  output logic [DWIDTH+1:0]   o_f_wdata,
  input  logic                i_f_full,
  output logic                o_busy,
  output logic                o_proto_err,
  output logic [15:0]         o_cell_cnt
);

  localparam int SOP_BIT = sop_bit(DWIDTH);
  localparam int EOP_BIT = eop_bit(DWIDTH);

  // Out-of-range parameters elaborate to nothing extra; U_DLY is kept only
  // for interface compatibility since the registers carry no delays.
  if (CWIDTH < 1 || CWIDTH > 8 || U_DLY < 0) begin : g_bad_param
  end

  logic [1:0]        state_r;
  logic [1:0]        nxt_state_s;
  logic [CWIDTH-1:0] wcnt_r;
  logic              in_pkt_r;
  logic              proto_err_r;
  logic [15:0]       cell_cnt_r;

  logic              ready_s;
  logic              wen_s;
  logic              xfer_s;
  logic              last_s;
  logic              weoc_s;
  logic [DWIDTH+1:0] wdata_s;

  assign last_s = (wcnt_r == {CWIDTH{1'b1}});
  assign xfer_s = i_s_valid & ready_s;
  assign weoc_s = wen_s & last_s;

  // Source handshake and FIFO write enable; all quiet while in reset
  always_comb begin
    ready_s = 1'b0;
    wen_s   = 1'b0;
    if (i_rst) begin
      ready_s = 1'b0;
      wen_s   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready_s = ~i_f_full;
          wen_s   = i_s_valid & ~i_f_full;
        end
        ST_FILL: begin
          ready_s = 1'b1;
          wen_s   = i_s_valid;
        end
        ST_PAD: begin
          ready_s = 1'b0;
          wen_s   = 1'b1;
        end
        default: begin
          ready_s = 1'b0;
          wen_s   = 1'b0;
        end
      endcase
    end
  end

  // FIFO word: pad filler in PAD, otherwise the source word with markers
  always_comb begin
    wdata_s = {2'b00, PAD_DATA};
    if (state_r == ST_PAD) begin
      wdata_s = {2'b00, PAD_DATA};
    end else begin
      wdata_s[DWIDTH-1:0] = i_s_data;
      wdata_s[SOP_BIT]    = i_s_sop;
      wdata_s[EOP_BIT]    = i_s_eop;
    end
  end

  // Next state: the cell boundary outranks eop, so no PAD on a full cell
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          nxt_state_s = i_s_eop ? ST_PAD : ST_FILL;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (xfer_s & last_s) begin
          nxt_state_s = ST_IDLE;
        end else if (xfer_s & i_s_eop) begin
          nxt_state_s = ST_PAD;
        end else begin
          nxt_state_s = ST_FILL;
        end
      end
      ST_PAD: begin
        if (last_s) begin
          nxt_state_s = ST_IDLE;
        end else begin
          nxt_state_s = ST_PAD;
        end
      end
      default: nxt_state_s = ST_IDLE;
    endcase
  end

  // State, in-cell counter, framing tracker and cell statistics
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      wcnt_r      <= {CWIDTH{1'b0}};
      in_pkt_r    <= 1'b0;
      proto_err_r <= 1'b0;
      cell_cnt_r  <= 16'd0;
    end else begin
      state_r <= nxt_state_s;
      if (weoc_s) begin
        wcnt_r     <= {CWIDTH{1'b0}};
        cell_cnt_r <= cell_cnt_r + 16'd1;
      end else if (wen_s) begin
        wcnt_r <= wcnt_r + CWIDTH'(1);
      end
      if (xfer_s) begin
        in_pkt_r <= in_pkt_next(i_s_sop, i_s_eop, in_pkt_r);
        if (proto_violation(i_s_sop, in_pkt_r)) begin
          proto_err_r <= 1'b1;
        end
      end
    end
  end

  assign o_s_ready   = ready_s;
  assign o_f_wen     = wen_s;
  assign o_f_weoc    = weoc_s;
  assign o_f_waddr   = i_rst ? {CWIDTH{1'b0}} : wcnt_r;
  assign o_f_wdata   = wdata_s;
  assign o_busy      = (state_r != ST_IDLE);
  assign o_proto_err = proto_err_r;
  assign o_cell_cnt  = cell_cnt_r;

endmodule

// File: tb/tb_sync_cell_fifo_wr.sv
// Self-checking bench for sync_cell_fifo_wr (DWIDTH=8, CWIDTH=2): vector
// table, directed corner sequences and a randomized run against a cell model.
module tb_sync_cell_fifo_wr;

  localparam logic [7:0] PAD = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_sop, s_eop, f_full;
  logic [7:0] s_data;
  logic       s_ready, f_wen, f_weoc, busy, proto_err;
  logic [1:0] f_waddr;
  logic [9:0] f_wdata;
  logic [15:0] cell_cnt;

  int n_checks = 0;
  int n_err    = 0;

  sync_cell_fifo_wr #(
    .DWIDTH(8), .CWIDTH(2), .PAD_DATA(PAD), .U_DLY(1)
  ) dut (
    .i_clk_sys(clk), .i_rst(rst),
    .i_s_valid(s_valid), .i_s_sop(s_sop), .i_s_eop(s_eop), .i_s_data(s_data),
    .o_s_ready(s_ready), .o_f_wen(f_wen), .o_f_weoc(f_weoc),
    .o_f_waddr(f_waddr), .o_f_wdata(f_wdata), .i_f_full(f_full),
    .o_busy(busy), .o_proto_err(proto_err), .o_cell_cnt(cell_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, valid, sop, eop, full;
    logic [7:0] data;
    logic       ready, wen, weoc;
    logic [1:0] waddr;
    logic [9:0] wdata;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic s, input logic e,
                       input logic f, input logic [7:0] d);
    rst = r; s_valid = v; s_sop = s; s_eop = e; f_full = f; s_data = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Random-phase model: position within the current cell plus pad mode
  int   m_pos, m_cells, g_idx, g_len;
  logic m_pad, m_inpkt, m_err;

  initial begin
    logic r, v, s, e, f, acc;
    logic [7:0] d;
    logic e_ready, e_wen, e_weoc;
    logic [9:0] e_wdata;

    vecs[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,8'h10, 1'b0,1'b0,1'b0,2'd0,10'h000};
    vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,8'h10, 1'b0,1'b0,1'b0,2'd0,10'h000};
    vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,8'h10, 1'b1,1'b1,1'b0,2'd0,10'h210};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,8'h11, 1'b1,1'b1,1'b0,2'd1,10'h011};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,8'h12, 1'b1,1'b1,1'b0,2'd2,10'h012};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,8'h13, 1'b1,1'b1,1'b1,2'd3,10'h013};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,8'h14, 1'b0,1'b0,1'b0,2'd0,10'h000};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,8'h14, 1'b1,1'b1,1'b0,2'd0,10'h114};
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,8'h20, 1'b0,1'b1,1'b0,2'd1,10'h05A};
    vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,8'h20, 1'b0,1'b1,1'b0,2'd2,10'h05A};
    vecs[10] = '{1'b0,1'b1,1'b1,1'b0,1'b0,8'h20, 1'b0,1'b1,1'b1,2'd3,10'h05A};
    vecs[11] = '{1'b0,1'b1,1'b1,1'b1,1'b0,8'h30, 1'b1,1'b1,1'b0,2'd0,10'h330};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,2'd1,10'h05A};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,2'd2,10'h05A};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,2'd3,10'h05A};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,2'd0,10'h000};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    next_cycle();
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", {31'd0, proto_err}, 32'd0);
    chk("reset_cnt", {16'd0, cell_cnt}, 32'd0);
    next_cycle();

    // Table: full gating, 4+1 packet with pad, sop&eop single word
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].sop, vecs[i].eop, vecs[i].full, vecs[i].data);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), {31'd0, s_ready}, {31'd0, vecs[i].ready});
      chk($sformatf("vec%0d_wen", i), {31'd0, f_wen}, {31'd0, vecs[i].wen});
      chk($sformatf("vec%0d_weoc", i), {31'd0, f_weoc}, {31'd0, vecs[i].weoc});
      chk($sformatf("vec%0d_waddr", i), {30'd0, f_waddr}, {30'd0, vecs[i].waddr});
      if (vecs[i].wen) chk($sformatf("vec%0d_wdata", i), {22'd0, f_wdata}, {22'd0, vecs[i].wdata});
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("vec_cnt", {16'd0, cell_cnt}, 32'd3);
    chk("vec_busy", {31'd0, busy}, 32'd0);
    chk("vec_err", {31'd0, proto_err}, 32'd0);
    next_cycle();

    // Eight-word packet: two exact cells, weoc on 3 and 7, no pad
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, (i == 0), (i == 7), 1'b0, 8'(8'h40 + i));
      @(negedge clk);
      chk($sformatf("p8_wen%0d", i), {31'd0, f_wen}, 32'd1);
      chk($sformatf("p8_waddr%0d", i), {30'd0, f_waddr}, 32'(i % 4));
      chk($sformatf("p8_weoc%0d", i), {31'd0, f_weoc}, {31'd0, ((i % 4) == 3)});
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("p8_cnt", {16'd0, cell_cnt}, 32'd2);
    chk("p8_nopad_ready", {31'd0, s_ready}, 32'd1);
    chk("p8_nopad_busy", {31'd0, busy}, 32'd0);
    next_cycle();

    // Protocol error: sop repeated mid-packet is still written, flag sticks
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, (i == 0) || (i == 2), (i == 3), 1'b0, 8'(8'h60 + i));
      @(negedge clk);
      chk($sformatf("pe_wen%0d", i), {31'd0, f_wen}, 32'd1);
      if (i == 2) begin
        chk("pe_wdata", {22'd0, f_wdata}, {22'd0, 2'b10, 8'h62});
        chk("pe_err_before", {31'd0, proto_err}, 32'd0);
      end
      if (i == 3) chk("pe_err_next", {31'd0, proto_err}, 32'd1);
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    next_cycle();
    @(negedge clk);
    chk("pe_err_sticky", {31'd0, proto_err}, 32'd1);
    chk("pe_cnt", {16'd0, cell_cnt}, 32'd3);

    // Reset at waddr 2 abandons the cell
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, (i == 0), 1'b0, 1'b0, 8'(8'h70 + i));
      next_cycle();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h72);
    @(negedge clk);
    chk("rst_mid_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_mid_wen", {31'd0, f_wen}, 32'd0);
    chk("rst_mid_weoc", {31'd0, f_weoc}, 32'd0);
    chk("rst_mid_waddr", {30'd0, f_waddr}, 32'd0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
    @(negedge clk);
    chk("rst_after_busy", {31'd0, busy}, 32'd0);
    chk("rst_after_err", {31'd0, proto_err}, 32'd0);
    chk("rst_after_cnt", {16'd0, cell_cnt}, 32'd0);
    chk("rst_after_waddr", {30'd0, f_waddr}, 32'd0);
    chk("rst_after_wen", {31'd0, f_wen}, 32'd1);
    next_cycle();

    // Randomized run against the cell model, starting from reset
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    next_cycle();
    m_pos = 0; m_pad = 1'b0; m_inpkt = 1'b0; m_err = 1'b0; m_cells = 0;
    g_idx = 0; g_len = 1 + int'($urandom % 10);
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom % 150) == 0;
      v = ($urandom % 10) < 7;
      s = (g_idx == 0);
      e = (g_idx == g_len - 1);
      if (($urandom % 60) == 0) s = ~s;
      d = 8'($urandom);
      f = ($urandom % 4) == 0;
      drive(r, v, s, e, f, d);

      e_ready = r ? 1'b0 : (m_pad ? 1'b0 : ((m_pos == 0) ? ~f : 1'b1));
      e_wen   = r ? 1'b0 : (m_pad ? 1'b1 : (v & e_ready));
      e_weoc  = e_wen && (m_pos == 3);
      e_wdata = m_pad ? {2'b00, PAD} : {s, e, d};

      @(negedge clk);
      chk("rnd_ready", {31'd0, s_ready}, {31'd0, e_ready});
      chk("rnd_wen", {31'd0, f_wen}, {31'd0, e_wen});
      chk("rnd_weoc", {31'd0, f_weoc}, {31'd0, e_weoc});
      chk("rnd_waddr", {30'd0, f_waddr}, r ? 32'd0 : 32'(m_pos));
      if (e_wen) chk("rnd_wdata", {22'd0, f_wdata}, {22'd0, e_wdata});
      chk("rnd_busy", {31'd0, busy}, {31'd0, (m_pad || m_pos != 0)});
      chk("rnd_err", {31'd0, proto_err}, {31'd0, m_err});
      chk("rnd_cnt", {16'd0, cell_cnt}, 32'(m_cells % 65536));

      acc = v & e_ready;
      if (r) begin
        m_pos = 0; m_pad = 1'b0; m_inpkt = 1'b0; m_err = 1'b0; m_cells = 0;
        g_idx = 0;
      end else begin
        if (acc) begin
          if ((s && m_inpkt) || (!s && !m_inpkt)) m_err = 1'b1;
          if (e) m_inpkt = 1'b0;
          else if (s) m_inpkt = 1'b1;
          if (e) begin
            g_idx = 0;
            g_len = 1 + int'($urandom % 10);
          end else begin
            g_idx++;
          end
        end
        if (e_wen) begin
          if (e_weoc) begin
            m_pos = 0; m_pad = 1'b0; m_cells++;
          end else begin
            m_pos++;
            if (acc && e) m_pad = 1'b1;
          end
        end
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
